// File: rtl/graph_pkg.sv
// Shared definitions for the graph edge server and the traversal core:
// default widths, configuration-bus select codes and FSM state encodings.
package graph_pkg;

  localparam int DEF_NODE_IDX_WIDTH  = 10;
  localparam int DEF_COUNTER_WIDTH   = 4;
  localparam int DEF_EDGE_ADDR_WIDTH = 12;

  // cfg_sel codes
  localparam logic NODE_TBL_SEL  = 1'b0;
  localparam logic EDGE_LIST_SEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_STREAM,
    S_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/graph_edge_server_if.sv
// Request/beat handshake and configuration bus between the traversal core
// (master) and the graph edge server (slave). Parameters must match the
// server's parameters.
interface graph_edge_server_if #(
  parameter int NODE_IDX_WIDTH  = graph_pkg::DEF_NODE_IDX_WIDTH,
  parameter int COUNTER_WIDTH   = graph_pkg::DEF_COUNTER_WIDTH,
  parameter int EDGE_ADDR_WIDTH = graph_pkg::DEF_EDGE_ADDR_WIDTH
) ();

  localparam int CFG_ADDR_WIDTH = graph_pkg::max_int(NODE_IDX_WIDTH, EDGE_ADDR_WIDTH);
  localparam int CFG_DATA_WIDTH = graph_pkg::max_int(EDGE_ADDR_WIDTH + COUNTER_WIDTH,
                                                     NODE_IDX_WIDTH);

  // request / beat stream
  logic [NODE_IDX_WIDTH-1:0]  node_idx;
  logic                       rd_next_node;
  logic [NODE_IDX_WIDTH-1:0]  next_node_idx;
  logic [COUNTER_WIDTH-1:0]   next_node_counter;
  logic                       next_node_valid;
  logic                       node_done;
  logic                       busy;

  // table configuration
  logic                       cfg_wr_en;
  logic                       cfg_sel;
  logic [CFG_ADDR_WIDTH-1:0]  cfg_addr;
  logic [CFG_DATA_WIDTH-1:0]  cfg_wdata;
  logic                       cfg_err;

  modport master (
    output node_idx, rd_next_node, cfg_wr_en, cfg_sel, cfg_addr, cfg_wdata,
    input  next_node_idx, next_node_counter, next_node_valid, node_done, busy, cfg_err
  );

  modport slave (
    input  node_idx, rd_next_node, cfg_wr_en, cfg_sel, cfg_addr, cfg_wdata,
    output next_node_idx, next_node_counter, next_node_valid, node_done, busy, cfg_err
  );

endinterface

// File: rtl/graph_sp_ram.sv
// Single-write-port RAM with a synchronous, one-cycle-latency read port.
module graph_sp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port and registered read port.
  // NOTE: storage arrays get no reset: contents must survive rst_n, and a
  // reset on the array would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wdata;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/graph_edge_server.sv
// Graph edge server: looks up a node's {base, count} entry in the node table
// and streams its successors from the edge list, one beat per cycle.
module graph_edge_server
  import graph_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = DEF_NODE_IDX_WIDTH,
  parameter int PARAM_COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
  parameter int PARAM_EDGE_ADDR_WIDTH = DEF_EDGE_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  graph_edge_server_if.slave bus
);

  localparam int NW           = PARAM_NODE_IDX_WIDTH;
  localparam int CW           = PARAM_COUNTER_WIDTH;
  localparam int EA           = PARAM_EDGE_ADDR_WIDTH;
  localparam int NODE_ENTRY_W = EA + CW;

  state_e         r_state;
  logic [NW-1:0]  r_node;
  logic [EA-1:0]  r_addr;    // edge address of the current beat
  logic [CW-1:0]  r_cnt;     // successors remaining, including the current beat
  logic           r_valid;
  logic           r_done;
  logic           r_busy;
  logic           r_err;

  logic                    w_cfg_ok;
  logic                    w_node_we;
  logic                    w_edge_we;
  logic [NODE_ENTRY_W-1:0] w_node_q;
  logic [EA-1:0]           w_node_base;
  logic [CW-1:0]           w_node_count;
  logic                    w_node_rd_en;
  logic                    w_edge_rd_en;
  logic [EA-1:0]           w_edge_rd_addr;
  logic [NW-1:0]           w_edge_q;

  // Config writes are only honoured while the server is idle, so a lookup
  // in flight never sees a half-updated node.
  assign w_cfg_ok  = bus.cfg_wr_en && !r_busy;
  assign w_node_we = w_cfg_ok && (bus.cfg_sel == NODE_TBL_SEL);
  assign w_edge_we = w_cfg_ok && (bus.cfg_sel == EDGE_LIST_SEL);

  assign w_node_base  = w_node_q[NODE_ENTRY_W-1:CW];
  assign w_node_count = w_node_q[CW-1:0];

  assign w_node_rd_en = (r_state == S_LOOKUP);
  assign w_edge_rd_en = (r_state == S_FETCH) || (r_state == S_STREAM);

  // Edge read address: the node base straight from the table in FETCH,
  // then one ahead of the current beat so the next beat has no bubble.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_edge_rd_addr = r_addr + EA'(1);
    if (r_state == S_FETCH) begin
      w_edge_rd_addr = w_node_base;
    end
  end

  graph_sp_ram #(
    .ADDR_WIDTH (NW),
    .DATA_WIDTH (NODE_ENTRY_W)
  ) u_node_tbl (
    .clk       (clk),
    .i_we      (w_node_we),
    .i_wr_addr (bus.cfg_addr[NW-1:0]),
    .i_wdata   (bus.cfg_wdata[NODE_ENTRY_W-1:0]),
    .i_rd_en   (w_node_rd_en),
    .i_rd_addr (r_node),
    .o_rd_data (w_node_q)
  );

  graph_sp_ram #(
    .ADDR_WIDTH (EA),
    .DATA_WIDTH (NW)
  ) u_edge_list (
    .clk       (clk),
    .i_we      (w_edge_we),
    .i_wr_addr (bus.cfg_addr[EA-1:0]),
    .i_wdata   (bus.cfg_wdata[NW-1:0]),
    .i_rd_en   (w_edge_rd_en),
    .i_rd_addr (w_edge_rd_addr),
    .o_rd_data (w_edge_q)
  );

  // Request FSM with registered valid/done/busy outputs.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_node  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.rd_next_node) begin
            r_node  <= bus.node_idx;
            r_busy  <= 1'b1;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_addr <= w_node_base;
          r_cnt  <= w_node_count;
          if (w_node_count == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_valid <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_cnt == CW'(1)) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt  <= r_cnt - CW'(1);
            r_addr <= r_addr + EA'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag for config writes dropped while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (bus.cfg_wr_en && r_busy) begin
      r_err <= 1'b1;
    end
  end

  // Beat data is forced to zero whenever no beat is presented.
  assign bus.next_node_valid   = r_valid;
  assign bus.next_node_idx     = r_valid ? w_edge_q : '0;
  assign bus.next_node_counter = r_valid ? r_cnt : '0;
  assign bus.node_done         = r_done;
  assign bus.busy              = r_busy;
  assign bus.cfg_err           = r_err;

endmodule

// File: doc/graph_edge_server.md
GRAPH_EDGE_SERVER -- requirements
Module: graph_edge_server

Interface
REQ-001 SHALL have parameter PARAM_NODE_IDX_WIDTH, default 10, node index width.
REQ-002 SHALL have parameter PARAM_COUNTER_WIDTH, default 4, edge-count width (max 15 successors per node).
REQ-003 SHALL have parameter PARAM_EDGE_ADDR_WIDTH, default 12, edge-list address width.
REQ-004 SHALL have ports: clk  in  1  sole clock; rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports: node_idx  in  NODE_IDX_WIDTH  index of the node whose successors are requested.
REQ-007 SHALL have ports: rd_next_node  in  1  request level from the traversal core.
REQ-008 SHALL have ports: next_node_idx  out  NODE_IDX_WIDTH  successor index of the current beat.
REQ-009 SHALL have ports: next_node_counter  out  COUNTER_WIDTH  successors remaining, including the current one; 1 on the last beat.
REQ-010 SHALL have ports: next_node_valid  out  1  a beat is presented this cycle.
REQ-011 SHALL have ports: node_done  out  1  one-cycle pulse after the last beat, or instead of any beat for a zero-edge node.
REQ-012 SHALL have ports: busy  out  1  FSM is not in IDLE.
REQ-013 SHALL have ports: cfg_wr_en  in  1  table write strobe.
REQ-014 SHALL have ports: cfg_sel  in  1  0 = node table, 1 = edge list.
REQ-015 SHALL have ports: cfg_addr  in  max(NODE_IDX_WIDTH, EDGE_ADDR_WIDTH)  write address; upper bits are ignored for the node table.
REQ-016 SHALL have ports: cfg_wdata  in  max(EDGE_ADDR_WIDTH + COUNTER_WIDTH, NODE_IDX_WIDTH)  write data.
REQ-017 SHALL have ports: cfg_err  out  1  sticky flag; set when a config write is dropped.

Function
REQ-018 SHALL store a node table of 2^NODE_IDX_WIDTH entries, each {base[EDGE_ADDR_WIDTH], count[COUNTER_WIDTH]}, with base in the MSBs of cfg_wdata.
REQ-019 SHALL store an edge list of 2^EDGE_ADDR_WIDTH entries, each NODE_IDX_WIDTH wide, taken from the LSBs of cfg_wdata.
REQ-020 SHALL read both memories synchronously with one-cycle latency.
REQ-021 SHALL implement FSM states IDLE, LOOKUP, FETCH, STREAM, DONE.
REQ-022 IDLE SHALL latch node_idx and go to LOOKUP when rd_next_node=1; otherwise it SHALL stay in IDLE.
REQ-023 LOOKUP SHALL issue the node-table read and go to FETCH.
REQ-024 FETCH SHALL register base and count, then:
- if count=0, go to DONE;
- otherwise issue the edge read at base and go to STREAM.
REQ-025 STREAM SHALL, each cycle:
- assert next_node_valid;
- drive next_node_idx = edge[base+i] and next_node_counter = count-i;
- pre-read edge[base+i+1].
REQ-026 STREAM SHALL go to DONE after the beat with counter=1.
REQ-027 DONE SHALL pulse node_done for one cycle and return to IDLE.
REQ-028 First-beat latency SHALL be 3 cycles after the request is sampled in IDLE; a node with N edges SHALL occupy N consecutive beat cycles with no bubbles.
REQ-029 Edge address arithmetic SHALL wrap modulo 2^EDGE_ADDR_WIDTH.
REQ-030 A held rd_next_node SHALL start a new request on the cycle after DONE, using node_idx sampled at that time.
REQ-031 rd_next_node SHALL be ignored outside IDLE.
REQ-032 cfg_wr_en SHALL write the selected memory only while busy=0.
REQ-033 cfg_wr_en while busy=1 SHALL drop the write and set cfg_err; cfg_err SHALL clear only on reset.
REQ-034 If cfg_wr_en and rd_next_node are both asserted in IDLE, the write SHALL complete and the request SHALL be accepted in the same cycle; the lookup SHALL see the new data when the same address is involved.
REQ-035 Outside STREAM, next_node_idx, next_node_counter and next_node_valid SHALL be 0.

Reset
REQ-036 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and next_node_idx, next_node_counter, next_node_valid, node_done, busy and cfg_err SHALL all be 0, including when reset is asserted mid-stream.
REQ-037 Node-table and edge-list contents SHALL NOT be reset; they SHALL retain their values across reset.

Structure
REQ-038 Package graph_pkg SHALL hold the state encodings, the cfg_sel constants (NODE_TBL_SEL = 0, EDGE_LIST_SEL = 1) and the default width constants shared with the traversal core.
REQ-039 The design SHALL instantiate sub-module graph_sp_ram (single write port, synchronous read, parameterised depth and width) twice: once for the node table and once for the edge list.

Verification
REQ-040 Load node 5 = {base 100, count 3} and edges 100..102 = 7, 9, 11; pulse the request for node 5 -> beats at request+3..+5 of (7,3), (9,2), (11,1); node_done at +6.
REQ-041 Request a node with count=0 -> no valid beats; node_done at request+3; busy low the next cycle.
REQ-042 Load base = 4094, count = 4 -> beats read edge addresses 4094, 4095, 0, 1 in order.
REQ-043 Hold rd_next_node high while changing node_idx from 5 to 6 during the stream -> node 5 completes, then node 6 starts on the cycle after DONE.
REQ-044 Issue cfg_wr_en during STREAM -> memory unchanged, cfg_err=1 and held; the stream is unaffected.
REQ-045 Assert rst_n=0 at the second beat -> all outputs 0 on the next edge, FSM in IDLE; a repeat request afterwards yields the identical beat sequence.
